// File: rtl/mc_controller_hs.sv
// Multi-cycle RV32I control FSM for the shared-memory datapath, with memory wait
// states, full branch set, LUI/AUIPC, 4-bit ALU control and illegal-instruction handling.
module mc_controller_hs #(
    parameter bit MEM_HANDSHAKE   = 1'b1,
    parameter bit SUPPORT_AUIPC   = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_EXEC_I    = 4'd3,
        S_ALU_WB    = 4'd4,
        S_MEM_ADR   = 4'd5,
        S_MEM_RD    = 4'd6,
        S_LOAD_WB   = 4'd7,
        S_MEM_WR    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_EXEC_JALR = 4'd11,
        S_LUI_WB    = 4'd12,
        S_AUIPC     = 4'd13,
        S_TRAP      = 4'd14
    } state_t;

    state_t state_q;
    state_t state_d;
    state_t dec_next;
    logic   dec_illegal;
    logic   mem_done;
    logic   taken;
    logic   is_shift;
    logic [3:0] alu_r;
    logic [3:0] alu_i;

    // Memory handshake: MemRead/MemWrite act as the request valid and, together with
    // AdrSrc, are held steady from the first cycle of an access until a cycle in which
    // mem_ready is 1; that cycle completes the access and the FSM advances on the next
    // edge. Without the handshake every access completes in its first cycle.
    assign mem_done = MEM_HANDSHAKE ? mem_ready : 1'b1;

    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: taken = 1'b0;
        endcase
    end

    // R-type honours funct7[5] for SUB/SRA; I-type only for SRAI, since its
    // funct7 field is immediate bits for ADDI.
    always_comb begin
        alu_r = ALU_ADD;
        alu_i = ALU_ADD;
        case (funct3)
            3'b000: begin
                alu_r = funct7[5] ? ALU_SUB : ALU_ADD;
                alu_i = ALU_ADD;
            end
            3'b001: begin
                alu_r = ALU_SLL;
                alu_i = ALU_SLL;
            end
            3'b010: begin
                alu_r = ALU_SLT;
                alu_i = ALU_SLT;
            end
            3'b011: begin
                alu_r = ALU_SLTU;
                alu_i = ALU_SLTU;
            end
            3'b100: begin
                alu_r = ALU_XOR;
                alu_i = ALU_XOR;
            end
            3'b101: begin
                alu_r = funct7[5] ? ALU_SRA : ALU_SRL;
                alu_i = funct7[5] ? ALU_SRA : ALU_SRL;
            end
            3'b110: begin
                alu_r = ALU_OR;
                alu_i = ALU_OR;
            end
            default: begin
                alu_r = ALU_AND;
                alu_i = ALU_AND;
            end
        endcase
    end

    always_comb begin
        dec_next    = S_FETCH;
        dec_illegal = 1'b0;
        case (op)
            OP_R: begin
                dec_next = S_EXEC_R;
                if ((funct7 != F7_BASE) && (funct7 != F7_ALT))
                    dec_illegal = 1'b1;
                if ((funct7 == F7_ALT) && (funct3 != 3'b000) && (funct3 != 3'b101))
                    dec_illegal = 1'b1;
            end
            OP_I: begin
                dec_next = S_EXEC_I;
                if (is_shift && (funct7 != F7_BASE) && (funct7 != F7_ALT))
                    dec_illegal = 1'b1;
            end
            OP_LOAD, OP_STORE: begin
                dec_next = S_MEM_ADR;
                if (funct3 != 3'b010)
                    dec_illegal = 1'b1;
            end
            OP_BRANCH: begin
                dec_next = S_BRANCH;
                if ((funct3 == 3'b010) || (funct3 == 3'b011))
                    dec_illegal = 1'b1;
            end
            OP_JAL: dec_next = S_JAL;
            OP_JALR: begin
                dec_next = S_EXEC_JALR;
                if (funct3 != 3'b000)
                    dec_illegal = 1'b1;
            end
            OP_LUI: dec_next = S_LUI_WB;
            OP_AUIPC: begin
                dec_next = S_AUIPC;
                if (!SUPPORT_AUIPC)
                    dec_illegal = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal)
            dec_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= S_FETCH;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_B;
        ImmSrc     = IMM_I;
        ALUControl = ALU_ADD;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead   = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                if (mem_done) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
                illegal = dec_illegal;
                state_d = dec_next;
            end
            S_EXEC_R: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_B;
                ALUControl = alu_r;
                state_d    = S_ALU_WB;
            end
            S_EXEC_I: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_I;
                ALUControl = alu_i;
                state_d    = S_ALU_WB;
            end
            S_ALU_WB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_ADR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
                state_d = (op == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                AdrSrc  = 1'b1;
                MemRead = 1'b1;
                if (mem_done)
                    state_d = S_LOAD_WB;
            end
            S_LOAD_WB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_WR: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_done)
                    state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_B;
                ALUControl = ALU_SUB;
                ResultSrc  = RES_ALUOUT;
                PCWrite    = taken;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                // PC <- ALUOut (target); ALU meanwhile forms OldPC + 4 for the link write.
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALUOUT;
                PCWrite   = 1'b1;
                state_d   = S_ALU_WB;
            end
            S_EXEC_JALR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_I;
                state_d = S_JAL;
            end
            S_LUI_WB: begin
                ImmSrc    = IMM_U;
                ResultSrc = RES_IMM;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_AUIPC: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_U;
                state_d = S_ALU_WB;
            end
            S_TRAP: begin
                illegal = 1'b1;
                state_d = S_TRAP;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_controller_hs.sv
// Scoreboard bench for mc_controller_hs: dut_a uses default parameters, dut_b has
// handshake, AUIPC and trapping disabled; both share stimulus.
module tb_mc_controller_hs;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       lt;
  logic       ltu;
  logic       mem_ready;

  logic       a_pcw, a_adr, a_mrd, a_mwr, a_irw, a_rgw, a_ill;
  logic [1:0] a_res, a_sa, a_sb;
  logic [2:0] a_imm;
  logic [3:0] a_alu, a_state;
  logic       b_pcw, b_adr, b_mrd, b_mwr, b_irw, b_rgw, b_ill;
  logic [1:0] b_res, b_sa, b_sb;
  logic [2:0] b_imm;
  logic [3:0] b_alu, b_state;

  mc_controller_hs dut_a (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .PCWrite(a_pcw), .AdrSrc(a_adr), .MemRead(a_mrd), .MemWrite(a_mwr),
    .IRWrite(a_irw), .RegWrite(a_rgw), .ResultSrc(a_res), .ALUSrcA(a_sa),
    .ALUSrcB(a_sb), .ImmSrc(a_imm), .ALUControl(a_alu), .illegal(a_ill),
    .state(a_state)
  );

  mc_controller_hs #(
    .MEM_HANDSHAKE(1'b0), .SUPPORT_AUIPC(1'b0), .TRAP_ON_ILLEGAL(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .PCWrite(b_pcw), .AdrSrc(b_adr), .MemRead(b_mrd), .MemWrite(b_mwr),
    .IRWrite(b_irw), .RegWrite(b_rgw), .ResultSrc(b_res), .ALUSrcA(b_sa),
    .ALUSrcB(b_sb), .ImmSrc(b_imm), .ALUControl(b_alu), .illegal(b_ill),
    .state(b_state)
  );

  // Packed as {state, PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
  //            ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal}
  localparam int W = 24;
  logic [W-1:0] act_a, act_b;
  assign act_a = {a_state, a_pcw, a_adr, a_mrd, a_mwr, a_irw, a_rgw,
                  a_res, a_sa, a_sb, a_imm, a_alu, a_ill};
  assign act_b = {b_state, b_pcw, b_adr, b_mrd, b_mwr, b_irw, b_rgw,
                  b_res, b_sa, b_sb, b_imm, b_alu, b_ill};

  localparam logic [W-1:0] V_FETCH_R = {4'd0,  6'b101010, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 1'b0};
  localparam logic [W-1:0] V_FETCH_N = {4'd0,  6'b001000, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 1'b0};
  localparam logic [W-1:0] V_DEC     = {4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 3'b010, 4'b0000, 1'b0};
  localparam logic [W-1:0] V_DEC_J   = {4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 3'b011, 4'b0000, 1'b0};
  localparam logic [W-1:0] V_DEC_ILL = {4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 3'b010, 4'b0000, 1'b1};
  localparam logic [W-1:0] V_EXR_ADD = {4'd2,  6'b000000, 2'b00, 2'b10, 2'b00, 3'b000, 4'b0000, 1'b0};
  localparam logic [W-1:0] V_EXR_SUB = {4'd2,  6'b000000, 2'b00, 2'b10, 2'b00, 3'b000, 4'b0001, 1'b0};
  localparam logic [W-1:0] V_EXI_SRA = {4'd3,  6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 4'b1001, 1'b0};
  localparam logic [W-1:0] V_EXI_ADD = {4'd3,  6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 4'b0000, 1'b0};
  localparam logic [W-1:0] V_ALU_WB  = {4'd4,  6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0};
  localparam logic [W-1:0] V_ADR_LD  = {4'd5,  6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 4'b0000, 1'b0};
  localparam logic [W-1:0] V_ADR_ST  = {4'd5,  6'b000000, 2'b00, 2'b10, 2'b01, 3'b001, 4'b0000, 1'b0};
  localparam logic [W-1:0] V_MEM_RD  = {4'd6,  6'b011000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0};
  localparam logic [W-1:0] V_LOAD_WB = {4'd7,  6'b000001, 2'b01, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0};
  localparam logic [W-1:0] V_MEM_WR  = {4'd8,  6'b010100, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0};
  localparam logic [W-1:0] V_BR_T    = {4'd9,  6'b100000, 2'b00, 2'b10, 2'b00, 3'b000, 4'b0001, 1'b0};
  localparam logic [W-1:0] V_BR_N    = {4'd9,  6'b000000, 2'b00, 2'b10, 2'b00, 3'b000, 4'b0001, 1'b0};
  localparam logic [W-1:0] V_JAL     = {4'd10, 6'b100000, 2'b00, 2'b01, 2'b10, 3'b000, 4'b0000, 1'b0};
  localparam logic [W-1:0] V_JALR    = {4'd11, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 4'b0000, 1'b0};
  localparam logic [W-1:0] V_LUI     = {4'd12, 6'b000001, 2'b11, 2'b00, 2'b00, 3'b100, 4'b0000, 1'b0};
  localparam logic [W-1:0] V_AUIPC   = {4'd13, 6'b000000, 2'b00, 2'b01, 2'b01, 3'b100, 4'b0000, 1'b0};
  localparam logic [W-1:0] V_TRAP    = {4'd14, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b1};

  localparam logic [6:0] O_R = 7'b0110011, O_I = 7'b0010011, O_LD = 7'b0000011;
  localparam logic [6:0] O_ST = 7'b0100011, O_BR = 7'b1100011, O_JAL = 7'b1101111;
  localparam logic [6:0] O_JALR = 7'b1100111, O_LUI = 7'b0110111, O_AUIPC = 7'b0010111;
  localparam logic [6:0] O_BAD = 7'b1111111;

  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  string        name_a_q[$];
  string        name_b_q[$];
  bit           chk_b;
  int           checks;
  int           errors;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: apply inputs just after the rising edge and queue the expected outputs
  task automatic cyc(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [2:0] flags, input logic rdy,
                     input logic [W-1:0] ea, input logic [W-1:0] eb, input string nm);
    op = o;
    funct3 = f3;
    funct7 = f7;
    {zero, lt, ltu} = flags;
    mem_ready = rdy;
    exp_a_q.push_back(ea);
    name_a_q.push_back(nm);
    if (chk_b) begin
      exp_b_q.push_back(eb);
      name_b_q.push_back(nm);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    chk_b = 1'b1;
    rst = 1'b1;
    cyc(7'd0, 3'd0, 7'd0, 3'b000, 1'b1, V_FETCH_R, V_FETCH_R, "rst_pulse");
    rst = 1'b0;
  endtask

  // scoreboard monitor: sample on the falling edge, away from the active edge
  always @(negedge clk) begin
    logic [W-1:0] e;
    string        n;
    if (exp_a_q.size() > 0) begin
      e = exp_a_q.pop_front();
      n = name_a_q.pop_front();
      checks++;
      if (act_a !== e) begin
        errors++;
        $display("FAIL %s dut_a got %h expected %h (t=%0t)", n, act_a, e, $time);
      end
    end
    if (exp_b_q.size() > 0) begin
      e = exp_b_q.pop_front();
      n = name_b_q.pop_front();
      checks++;
      if (act_b !== e) begin
        errors++;
        $display("FAIL %s dut_b got %h expected %h (t=%0t)", n, act_b, e, $time);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    chk_b = 1'b1;
    rst = 1'b1;
    op = '0; funct3 = '0; funct7 = '0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    // In reset: FETCH decode; dut_a gates IRWrite/PCWrite with mem_ready, dut_b ignores it
    cyc(7'd0, 3'd0, 7'd0, 3'b000, 1'b0, V_FETCH_N, V_FETCH_R, "reset");
    rst = 1'b0;

    // ADD x3,x1,x2
    cyc(O_R, 3'b000, 7'h00, 3'b000, 1'b1, V_FETCH_R, V_FETCH_R, "add_fetch");
    cyc(O_R, 3'b000, 7'h00, 3'b000, 1'b1, V_DEC,     V_DEC,     "add_dec");
    cyc(O_R, 3'b000, 7'h00, 3'b000, 1'b1, V_EXR_ADD, V_EXR_ADD, "add_exec");
    cyc(O_R, 3'b000, 7'h00, 3'b000, 1'b1, V_ALU_WB,  V_ALU_WB,  "add_wb");
    // SUB
    cyc(O_R, 3'b000, 7'h20, 3'b000, 1'b1, V_FETCH_R, V_FETCH_R, "sub_fetch");
    cyc(O_R, 3'b000, 7'h20, 3'b000, 1'b1, V_DEC,     V_DEC,     "sub_dec");
    cyc(O_R, 3'b000, 7'h20, 3'b000, 1'b1, V_EXR_SUB, V_EXR_SUB, "sub_exec");
    cyc(O_R, 3'b000, 7'h20, 3'b000, 1'b1, V_ALU_WB,  V_ALU_WB,  "sub_wb");
    // SRAI
    cyc(O_I, 3'b101, 7'h20, 3'b000, 1'b1, V_FETCH_R, V_FETCH_R, "srai_fetch");
    cyc(O_I, 3'b101, 7'h20, 3'b000, 1'b1, V_DEC,     V_DEC,     "srai_dec");
    cyc(O_I, 3'b101, 7'h20, 3'b000, 1'b1, V_EXI_SRA, V_EXI_SRA, "srai_exec");
    cyc(O_I, 3'b101, 7'h20, 3'b000, 1'b1, V_ALU_WB,  V_ALU_WB,  "srai_wb");
    // ADDI with immediate bit 30 set must stay ADD
    cyc(O_I, 3'b000, 7'h20, 3'b000, 1'b1, V_FETCH_R, V_FETCH_R, "addi_fetch");
    cyc(O_I, 3'b000, 7'h20, 3'b000, 1'b1, V_DEC,     V_DEC,     "addi_dec");
    cyc(O_I, 3'b000, 7'h20, 3'b000, 1'b1, V_EXI_ADD, V_EXI_ADD, "addi_exec");
    cyc(O_I, 3'b000, 7'h20, 3'b000, 1'b1, V_ALU_WB,  V_ALU_WB,  "addi_wb");
    // JAL
    cyc(O_JAL, 3'b000, 7'h00, 3'b000, 1'b1, V_FETCH_R, V_FETCH_R, "jal_fetch");
    cyc(O_JAL, 3'b000, 7'h00, 3'b000, 1'b1, V_DEC_J,   V_DEC_J,   "jal_dec");
    cyc(O_JAL, 3'b000, 7'h00, 3'b000, 1'b1, V_JAL,     V_JAL,     "jal_jump");
    cyc(O_JAL, 3'b000, 7'h00, 3'b000, 1'b1, V_ALU_WB,  V_ALU_WB,  "jal_wb");
    // JALR
    cyc(O_JALR, 3'b000, 7'h00, 3'b000, 1'b1, V_FETCH_R, V_FETCH_R, "jalr_fetch");
    cyc(O_JALR, 3'b000, 7'h00, 3'b000, 1'b1, V_DEC,     V_DEC,     "jalr_dec");
    cyc(O_JALR, 3'b000, 7'h00, 3'b000, 1'b1, V_JALR,    V_JALR,    "jalr_exec");
    cyc(O_JALR, 3'b000, 7'h00, 3'b000, 1'b1, V_JAL,     V_JAL,     "jalr_jump");
    cyc(O_JALR, 3'b000, 7'h00, 3'b000, 1'b1, V_ALU_WB,  V_ALU_WB,  "jalr_wb");
    // LUI
    cyc(O_LUI, 3'b000, 7'h00, 3'b000, 1'b1, V_FETCH_R, V_FETCH_R, "lui_fetch");
    cyc(O_LUI, 3'b000, 7'h00, 3'b000, 1'b1, V_DEC,     V_DEC,     "lui_dec");
    cyc(O_LUI, 3'b000, 7'h00, 3'b000, 1'b1, V_LUI,     V_LUI,     "lui_wb");
    // Branches: flags = {zero, lt, ltu}
    cyc(O_BR, 3'b111, 7'h00, 3'b000, 1'b1, V_FETCH_R, V_FETCH_R, "bgeu_fetch");
    cyc(O_BR, 3'b111, 7'h00, 3'b000, 1'b1, V_DEC,     V_DEC,     "bgeu_dec");
    cyc(O_BR, 3'b111, 7'h00, 3'b000, 1'b1, V_BR_T,    V_BR_T,    "bgeu_taken");
    cyc(O_BR, 3'b110, 7'h00, 3'b000, 1'b1, V_FETCH_R, V_FETCH_R, "bltu_fetch");
    cyc(O_BR, 3'b110, 7'h00, 3'b000, 1'b1, V_DEC,     V_DEC,     "bltu_dec");
    cyc(O_BR, 3'b110, 7'h00, 3'b000, 1'b1, V_BR_N,    V_BR_N,    "bltu_not_taken");
    cyc(O_BR, 3'b000, 7'h00, 3'b100, 1'b1, V_FETCH_R, V_FETCH_R, "beq_fetch");
    cyc(O_BR, 3'b000, 7'h00, 3'b100, 1'b1, V_DEC,     V_DEC,     "beq_dec");
    cyc(O_BR, 3'b000, 7'h00, 3'b100, 1'b1, V_BR_T,    V_BR_T,    "beq_taken");
    cyc(O_BR, 3'b001, 7'h00, 3'b100, 1'b1, V_FETCH_R, V_FETCH_R, "bne_fetch");
    cyc(O_BR, 3'b001, 7'h00, 3'b100, 1'b1, V_DEC,     V_DEC,     "bne_dec");
    cyc(O_BR, 3'b001, 7'h00, 3'b100, 1'b1, V_BR_N,    V_BR_N,    "bne_not_taken");
    cyc(O_BR, 3'b100, 7'h00, 3'b010, 1'b1, V_FETCH_R, V_FETCH_R, "blt_fetch");
    cyc(O_BR, 3'b100, 7'h00, 3'b010, 1'b1, V_DEC,     V_DEC,     "blt_dec");
    cyc(O_BR, 3'b100, 7'h00, 3'b010, 1'b1, V_BR_T,    V_BR_T,    "blt_taken");
    // SW, zero-wait
    cyc(O_ST, 3'b010, 7'h00, 3'b000, 1'b1, V_FETCH_R, V_FETCH_R, "sw_fetch");
    cyc(O_ST, 3'b010, 7'h00, 3'b000, 1'b1, V_DEC,     V_DEC,     "sw_dec");
    cyc(O_ST, 3'b010, 7'h00, 3'b000, 1'b1, V_ADR_ST,  V_ADR_ST,  "sw_adr");
    cyc(O_ST, 3'b010, 7'h00, 3'b000, 1'b1, V_MEM_WR,  V_MEM_WR,  "sw_wr");
    // AUIPC: supported in dut_a, illegal (skipped) in dut_b
    cyc(O_AUIPC, 3'b000, 7'h00, 3'b000, 1'b1, V_FETCH_R, V_FETCH_R, "auipc_fetch");
    cyc(O_AUIPC, 3'b000, 7'h00, 3'b000, 1'b1, V_DEC,     V_DEC_ILL, "auipc_dec");
    cyc(O_AUIPC, 3'b000, 7'h00, 3'b000, 1'b1, V_AUIPC,   V_FETCH_R, "auipc_exec");
    cyc(O_AUIPC, 3'b000, 7'h00, 3'b000, 1'b1, V_ALU_WB,  V_DEC_ILL, "auipc_wb");

    // LW with three wait cycles in MEM_RD; dut_b spends one cycle per memory state
    cyc(O_LD, 3'b010, 7'h00, 3'b000, 1'b1, V_FETCH_R, V_FETCH_R, "lw_fetch");
    cyc(O_LD, 3'b010, 7'h00, 3'b000, 1'b1, V_DEC,     V_DEC,     "lw_dec");
    cyc(O_LD, 3'b010, 7'h00, 3'b000, 1'b1, V_ADR_LD,  V_ADR_LD,  "lw_adr");
    cyc(O_LD, 3'b010, 7'h00, 3'b000, 1'b0, V_MEM_RD,  V_MEM_RD,  "lw_rd_wait1");
    cyc(O_LD, 3'b010, 7'h00, 3'b000, 1'b0, V_MEM_RD,  V_LOAD_WB, "lw_rd_wait2");
    cyc(O_LD, 3'b010, 7'h00, 3'b000, 1'b0, V_MEM_RD,  V_FETCH_R, "lw_rd_wait3");
    cyc(O_LD, 3'b010, 7'h00, 3'b000, 1'b1, V_MEM_RD,  V_DEC,     "lw_rd_done");
    chk_b = 1'b0;
    cyc(O_LD, 3'b010, 7'h00, 3'b000, 1'b1, V_LOAD_WB, V_LOAD_WB, "lw_wb");
    cyc(O_LD, 3'b010, 7'h00, 3'b000, 1'b1, V_FETCH_R, V_FETCH_R, "lw_next_fetch");
    rst_pulse();

    // Unknown opcode: dut_a traps, dut_b skips back to FETCH
    cyc(O_BAD, 3'b000, 7'h00, 3'b000, 1'b1, V_FETCH_R, V_FETCH_R, "bad_fetch");
    cyc(O_BAD, 3'b000, 7'h00, 3'b000, 1'b1, V_DEC_ILL, V_DEC_ILL, "bad_dec");
    cyc(O_BAD, 3'b000, 7'h00, 3'b000, 1'b1, V_TRAP,    V_FETCH_R, "bad_trap0");
    cyc(O_BAD, 3'b000, 7'h00, 3'b000, 1'b1, V_TRAP,    V_DEC_ILL, "bad_trap1");
    chk_b = 1'b0;
    for (int i = 2; i < 10; i++)
      cyc(O_BAD, 3'b000, 7'h00, 3'b000, i[0], V_TRAP, V_TRAP, "bad_trap_sticky");
    rst_pulse();

    // Other illegal decodes
    cyc(O_LD, 3'b000, 7'h00, 3'b000, 1'b1, V_FETCH_R, V_FETCH_R, "lb_fetch");
    cyc(O_LD, 3'b000, 7'h00, 3'b000, 1'b1, V_DEC_ILL, V_DEC_ILL, "lb_dec");
    cyc(O_LD, 3'b000, 7'h00, 3'b000, 1'b1, V_TRAP,    V_FETCH_R, "lb_trap");
    rst_pulse();
    cyc(O_R, 3'b001, 7'h20, 3'b000, 1'b1, V_FETCH_R, V_FETCH_R, "r_alt_fetch");
    cyc(O_R, 3'b001, 7'h20, 3'b000, 1'b1, V_DEC_ILL, V_DEC_ILL, "r_alt_dec");
    cyc(O_R, 3'b001, 7'h20, 3'b000, 1'b1, V_TRAP,    V_FETCH_R, "r_alt_trap");
    rst_pulse();
    cyc(O_BR, 3'b010, 7'h00, 3'b000, 1'b1, V_FETCH_R, V_FETCH_R, "br010_fetch");
    cyc(O_BR, 3'b010, 7'h00, 3'b000, 1'b1, V_DEC_ILL, V_DEC_ILL, "br010_dec");
    cyc(O_I, 3'b001, 7'h01, 3'b000, 1'b1, V_TRAP,    V_FETCH_R, "br010_trap");
    cyc(O_I, 3'b001, 7'h01, 3'b000, 1'b1, V_TRAP,    V_DEC_ILL, "slli_bad_dec");
    rst_pulse();

    // Reset in the middle of a stalled store
    cyc(O_ST, 3'b010, 7'h00, 3'b000, 1'b1, V_FETCH_R, V_FETCH_R, "swr_fetch");
    cyc(O_ST, 3'b010, 7'h00, 3'b000, 1'b1, V_DEC,     V_DEC,     "swr_dec");
    cyc(O_ST, 3'b010, 7'h00, 3'b000, 1'b1, V_ADR_ST,  V_ADR_ST,  "swr_adr");
    cyc(O_ST, 3'b010, 7'h00, 3'b000, 1'b0, V_MEM_WR,  V_MEM_WR,  "swr_wr_wait");
    chk_b = 1'b0;
    cyc(O_ST, 3'b010, 7'h00, 3'b000, 1'b0, V_MEM_WR,  V_MEM_WR,  "swr_wr_hold");
    #1;
    rst = 1'b1;
    cyc(O_ST, 3'b010, 7'h00, 3'b000, 1'b0, V_FETCH_N, V_FETCH_N, "swr_async_rst");
    rst = 1'b0;
    chk_b = 1'b1;
    cyc(O_R, 3'b000, 7'h00, 3'b000, 1'b1, V_FETCH_R, V_FETCH_R, "post_rst_fetch");
    cyc(O_R, 3'b000, 7'h00, 3'b000, 1'b1, V_DEC,     V_DEC,     "post_rst_dec");

    @(negedge clk);
    #1;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending_a %0d pending_b %0d required 0", exp_a_q.size(), exp_b_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
